// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin arbiter sharing one SPI master among NUM_REQ requesters
// Optional watchdog abort of a stuck transfer is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DW          = 12,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*DW-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic                  spi_newd_o,
  output logic [DW-1:0]         spi_din_o,
  input  logic                  spi_cs_i
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } state_e;

  state_e        state_q;
  logic [PW-1:0] rr_q;
  logic [PW-1:0] win_q;
  logic [PW-1:0] win_d;
  logic          win_vld_d;
  logic [PW-1:0] rr_d;
  logic          tmo;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("spi_req_arbiter: parameter out of range");
  end

  // Scan downward so the requester closest to rr_q (wrapping upward) is written last and wins.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    win_vld_d = 1'b0;
    win_d     = rr_q;
    sum       = '0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) begin
        sum = sum - (PW+1)'(NUM_REQ);
      end
      idx = sum[PW-1:0];
      if (req_i[idx]) begin
        win_vld_d = 1'b1;
        win_d     = idx;
      end
    end
  end

  assign rr_d = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + PW'(1);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt_q;

  // Held at zero in IDLE, so it starts from zero on the cycle LAUNCH is entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tmo = (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      win_q      <= '0;
      ack_o      <= '0;
      done_o     <= '0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
      spi_newd_o <= 1'b0;
      spi_din_o  <= '0;
    end else begin
      ack_o  <= '0;
      done_o <= '0;
      err_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld_d && spi_cs_i) begin
            win_q      <= win_d;
            ack_o      <= NUM_REQ'(1) << win_d;
            spi_din_o  <= req_data_i[int'(win_d)*DW +: DW];
            spi_newd_o <= 1'b1;
            busy_o     <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH, BUSY: begin
          if (tmo) begin
            spi_newd_o <= 1'b0;
            err_o      <= 1'b1;
            done_o     <= NUM_REQ'(1) << win_q;
            rr_q       <= rr_d;
            busy_o     <= 1'b0;
            state_q    <= IDLE;
          end else if (state_q == LAUNCH) begin
            if (!spi_cs_i) begin
              spi_newd_o <= 1'b0;
              state_q    <= BUSY;
            end
          end else if (spi_cs_i) begin
            done_o  <= NUM_REQ'(1) << win_q;
            rr_q    <= rr_d;
            busy_o  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          spi_newd_o <= 1'b0;
          busy_o     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule
